// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch FSM state encodings and fetch-stage constants.
package fetch_unit_pkg;
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_VALID = 2'd2
  } fetch_state_t;
  localparam logic [2:0]  STAGE_FETCH = 3'd1;
  localparam logic [31:0] INSN_BYTES_DEF = 32'd4;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg: program counter with redirect/advance/hold mux and sticky misaligned flag.
module fetch_unit_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INSN_BYTES = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic        inc,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic        misaligned
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      pc <= redirect ? {target[31:2], 2'b00} : inc ? pc + INSN_BYTES : pc;
      misaligned <= misaligned | (redirect & |target[1:0]);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage (PC, imem request FSM, latched instruction).
// Optional FETCH_PERF_EN adds fetch_count_o/stall_count_o performance counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INSN_BYTES = INSN_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stage_i,
  input  logic        pc_readin_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        fetch_busy_o,
  output logic        misaligned_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
`endif
);
  fetch_state_t state;

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC), .INSN_BYTES(INSN_BYTES)) u_pc (
    .clk(clk),
    .reset(reset),
    .redirect(redirect_i),
    .inc(state == FETCH_VALID && pc_readin_i),
    .target(redirect_pc_i),
    .pc(pc_o),
    .misaligned(misaligned_o)
  );

  assign fetch_busy_o = state == FETCH_REQ;

  // A redirect abandons whatever is in flight, including a same-cycle ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH_IDLE;
      imem_req_o <= 1'b0;
      imem_addr_o <= 32'h0;
      instr_o <= 32'h0;
      instr_valid_o <= 1'b0;
    end else if (redirect_i) begin
      state <= FETCH_IDLE;
      imem_req_o <= 1'b0;
      instr_valid_o <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: if (stage_i == STAGE_FETCH) begin
          state <= FETCH_REQ;
          imem_addr_o <= pc_o;
          imem_req_o <= 1'b1;
        end
        FETCH_REQ: if (imem_ready_i) begin
          state <= FETCH_VALID;
          instr_o <= imem_data_i;
          instr_valid_o <= 1'b1;
          imem_req_o <= 1'b0;
        end
        FETCH_VALID: if (pc_readin_i) begin
          state <= FETCH_IDLE;
          instr_valid_o <= 1'b0;
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_o <= 32'h0;
      stall_count_o <= 32'h0;
    end else begin
      fetch_count_o <= fetch_count_o + {31'h0, fetch_busy_o & imem_ready_i & ~redirect_i};
      stall_count_o <= stall_count_o + {31'h0, fetch_busy_o & ~imem_ready_i};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized check of fetch_unit against a behavioural model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  stage_i = 3'd0;
  logic        pc_readin_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        fetch_busy_o;
  logic        misaligned_o;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_o;
  logic [31:0] stall_count_o;
`endif

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .stage_i(stage_i),
    .pc_readin_i(pc_readin_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i),
    .imem_data_i(imem_data_i),
    .pc_o(pc_o),
    .instr_o(instr_o),
    .instr_valid_o(instr_valid_o),
    .fetch_busy_o(fetch_busy_o),
    .misaligned_o(misaligned_o)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count_o(fetch_count_o),
    .stall_count_o(stall_count_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: phase 0 = waiting to fetch, 1 = request outstanding, 2 = holding an instruction.
  int          m_phase;
  logic [31:0] m_pc, m_addr, m_instr, m_fc, m_sc;
  logic        m_req, m_valid, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc = 32'h0;
    m_addr = 32'h0;
    m_instr = 32'h0;
    m_req = 1'b0;
    m_valid = 1'b0;
    m_mis = 1'b0;
    m_fc = 32'h0;
    m_sc = 32'h0;
  endtask

  task automatic model_step();
    if (m_phase == 1 && !imem_ready_i) m_sc = m_sc + 1;
    if (redirect_i) begin
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      if (redirect_pc_i[1:0] != 2'b00) m_mis = 1'b1;
      m_req = 1'b0;
      m_valid = 1'b0;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (stage_i == 3'd1) begin
        m_addr = m_pc;
        m_req = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (imem_ready_i) begin
        m_instr = imem_data_i;
        m_valid = 1'b1;
        m_req = 1'b0;
        m_fc = m_fc + 1;
        m_phase = 2;
      end
    end else if (pc_readin_i) begin
      m_pc = m_pc + 4;
      m_valid = 1'b0;
      m_phase = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, m_req});
    chk({tag, ".addr"}, imem_addr_o, m_addr);
    chk({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, m_valid});
    chk({tag, ".instr"}, instr_o, m_instr);
    chk({tag, ".busy"}, {31'h0, fetch_busy_o}, {31'h0, m_phase == 1});
    chk({tag, ".mis"}, {31'h0, misaligned_o}, {31'h0, m_mis});
`ifdef FETCH_PERF_EN
    chk({tag, ".fcnt"}, fetch_count_o, m_fc);
    chk({tag, ".scnt"}, stall_count_o, m_sc);
`endif
  endtask

  task automatic drive(input logic [2:0] st, input logic rd, input logic r, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] d);
    stage_i = st;
    pc_readin_i = rd;
    redirect_i = r;
    redirect_pc_i = rpc;
    imem_ready_i = rdy;
    imem_data_i = d;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    check_all(tag);
  endtask

  // Entered at posedge+1; pulses reset between edges and checks the immediate clear.
  task automatic areset(input string tag);
    #3 reset = 1'b0;
    #1 model_reset();
    check_all(tag);
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 check_all("rst");
    #10 reset = 1'b1;
    drive(3'd1, 0, 0, 0, 0, 0);
    step("t1_idle");
    chk("t1_addr", imem_addr_o, 32'h0);
    drive(3'd1, 0, 0, 0, 1, 32'h0000_0013);
    step("t1_ready");
    chk("t1_instr", instr_o, 32'h13);
    chk("t1_valid", {31'h0, instr_valid_o}, 32'h1);
    drive(3'd1, 1, 0, 0, 0, 0);
    step("t1_readin");
    chk("t1_pc", pc_o, 32'h4);

    areset("t2_rst");
    drive(3'd1, 0, 0, 0, 0, 0);
    step("t2_start");
    for (int i = 0; i < 5; i++) begin
      drive(3'd1, 0, 0, 0, 0, 32'hBAD0_0000);
      step("t2_wait");
      chk("t2_req", {31'h0, imem_req_o}, 32'h1);
      chk("t2_busy", {31'h0, fetch_busy_o}, 32'h1);
      chk("t2_noval", {31'h0, instr_valid_o}, 32'h0);
    end
`ifdef FETCH_PERF_EN
    chk("t2_stall", stall_count_o, 32'd5);
`endif
    drive(3'd1, 0, 0, 0, 1, 32'h1234_5678);
    step("t2_ready");
    chk("t2_instr", instr_o, 32'h1234_5678);
    drive(3'd1, 1, 0, 0, 0, 0);
    step("t2_readin");

    drive(3'd1, 0, 0, 0, 0, 0);
    step("t3_req");
    drive(3'd1, 0, 1, 32'h0000_0100, 1, 32'hDEAD_BEEF);
    step("t3_redir");
    chk("t3_valid", {31'h0, instr_valid_o}, 32'h0);
    drive(3'd1, 0, 0, 0, 0, 0);
    step("t3_refetch");
    chk("t3_addr", imem_addr_o, 32'h100);

    drive(3'd1, 0, 0, 0, 1, 32'h0000_0093);
    step("t4_valid");
    drive(3'd1, 1, 1, 32'h0000_0203, 0, 0);
    step("t4_redir");
    chk("t4_pc", pc_o, 32'h200);
    chk("t4_mis", {31'h0, misaligned_o}, 32'h1);

    drive(3'd1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step("t5_redir");
    drive(3'd1, 0, 0, 0, 0, 0);
    step("t5_req");
    drive(3'd1, 0, 0, 0, 1, 32'h0000_0073);
    step("t5_valid");
    drive(3'd1, 1, 0, 0, 0, 0);
    step("t5_wrap");
    chk("t5_pc", pc_o, 32'h0);
    chk("t5_mis", {31'h0, misaligned_o}, 32'h1);

    drive(3'd1, 0, 0, 0, 0, 0);
    step("t6_req");
    #3 reset = 1'b0;
    #1 model_reset();
    chk("t6_req0", {31'h0, imem_req_o}, 32'h0);
    chk("t6_pc", pc_o, 32'h0);
    check_all("t6_async");
    drive(3'd1, 0, 0, 0, 1, 32'hCAFE_F00D);
    step("t6_late");
    chk("t6_late_valid", {31'h0, instr_valid_o}, 32'h0);
    #4 reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      drive(($urandom_range(4) != 0) ? 3'd1 : 3'($urandom_range(7)),
            1'($urandom_range(1)),
            $urandom_range(11) == 0,
            t,
            1'($urandom_range(1)),
            $urandom);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
